// File: rtl/reorder_buffer_pkg.sv
// ---------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared definitions for the reorder buffer and its query ports:
//   ROB_SIZE / ROBW   - entry count and id width
//   ROB_ID_BUS_W      - width of every ROB id bus (rename tag)
//   id_type_e         - instruction class carried from decode
//   TRUE / FALSE      - single-bit constants
// ---------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_SIZE     = 16;
  localparam int ROBW         = $clog2(ROB_SIZE);
  localparam int ROB_ID_BUS_W = ROBW;

  typedef logic [ROB_ID_BUS_W-1:0] rob_id_t;
  typedef logic [ROBW:0]           rob_cnt_t;

  // Count value at which the buffer is full (one bit wider than an id).
  localparam rob_cnt_t ROB_COUNT_FULL = rob_cnt_t'(ROB_SIZE);

  typedef enum logic [1:0] {
    TYPE_ALU    = 2'd0,  // ALU op or load: writes the register file
    TYPE_BRANCH = 2'd1,
    TYPE_STORE  = 2'd2
  } id_type_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/rob_query_port.sv
// ---------------------------------------------------------------------------
// rob_query_port
// One operand lookup into the reorder buffer. Answers whether the entry named
// by i_q_id holds a finished result, and what that result is.
//
// Optional feature macro: ROB_CDB_BYPASS_EN
//   defined   - a same-cycle ALU or LSB broadcast to i_q_id is forwarded
//               combinationally (ready = 1, broadcast value).
//   undefined - only stored entry state is reported.
//
// Ports:
//   i_q_id                     queried ROB id
//   i_busy / i_ready           per-entry status vectors
//   i_value                    per-entry result values
//   i_alu_valid/_id/_value     ALU broadcast bus (used only with bypass)
//   i_lsb_valid/_id/_value     LSB broadcast bus (used only with bypass)
//   o_ready / o_value          lookup answer; o_value is meaningless when
//                              o_ready is 0
// ---------------------------------------------------------------------------
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  rob_id_t             i_q_id,
  input  logic [ROB_SIZE-1:0] i_busy,
  input  logic [ROB_SIZE-1:0] i_ready,
  input  logic [31:0]         i_value [ROB_SIZE],
  input  logic                i_alu_valid,
  input  rob_id_t             i_alu_id,
  input  logic [31:0]         i_alu_value,
  input  logic                i_lsb_valid,
  input  rob_id_t             i_lsb_id,
  input  logic [31:0]         i_lsb_value,
  output logic                o_ready,
  output logic [31:0]         o_value
);

  always_comb begin
    o_ready = i_busy[i_q_id] & i_ready[i_q_id];
    o_value = i_value[i_q_id];
`ifdef ROB_CDB_BYPASS_EN
    // ALU checked last so it wins if both buses name the same id.
    if (i_lsb_valid && (i_lsb_id == i_q_id)) begin
      o_ready = TRUE;
      o_value = i_lsb_value;
    end
    if (i_alu_valid && (i_alu_id == i_q_id)) begin
      o_ready = TRUE;
      o_value = i_alu_value;
    end
`endif
  end

`ifndef ROB_CDB_BYPASS_EN
  // Broadcast buses are only consumed by the bypass path.
  logic w_unused_bcast;
  assign w_unused_bcast = ^{i_alu_valid, i_alu_id, i_alu_value,
                            i_lsb_valid, i_lsb_id, i_lsb_value};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// Circular in-order retirement queue. Allocates one entry per issued
// instruction (its id is the destination rename tag), collects results from
// the ALU and LSB broadcast buses, and retires entries strictly in program
// order: register write-back, store release, or branch roll-back.
//
// Optional feature macro: ROB_CDB_BYPASS_EN (same-cycle broadcast forwarding
// on the two operand query ports, see rob_query_port).
//
// Ports:
//   clk, rst (async active-low), rdy (0 freezes all state and outputs)
//   ID_*            issue: valid, type, rd_valid/rd, pred_taken
//   ROB_free_id     id the next issued entry receives (combinational)
//   ROB_full        registered, count == ROB_SIZE
//   ALU_*           ALU broadcast: id, value, taken, target pc
//   LSB_*           LSB broadcast: id, value
//   Q1_*/Q2_*       operand queries (combinational answers)
//   RF_*            register write-back pulse
//   LSB_store_*     store release pulse
//   ROB_roll_back_flag / ROB_jump_pc  mispredict flush pulse
//
// Handshake: there is no backpressure on any bus. An issue is taken on an
// edge where ID_issue_valid=1, ROB_full=0 and ROB_roll_back_flag=0, otherwise
// it is dropped. A broadcast is taken on an edge where its valid is 1, the
// named entry is busy and no roll-back is in progress. All commit outputs are
// one-cycle pulses with no acknowledge.
// ---------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  // issue
  input  logic        ID_issue_valid,
  input  logic [1:0]  ID_type,
  input  logic        ID_rd_valid,
  input  logic [4:0]  ID_rd,
  input  logic        ID_pred_taken,
  output rob_id_t     ROB_free_id,
  output logic        ROB_full,
  // ALU broadcast
  input  logic        ALU_valid,
  input  rob_id_t     ALU_ROB_id,
  input  logic [31:0] ALU_value,
  input  logic        ALU_taken,
  input  logic [31:0] ALU_target_pc,
  // LSB broadcast
  input  logic        LSB_valid,
  input  rob_id_t     LSB_ROB_id,
  input  logic [31:0] LSB_value,
  // operand queries
  input  rob_id_t     Q1_id,
  input  rob_id_t     Q2_id,
  output logic        Q1_ready,
  output logic [31:0] Q1_value,
  output logic        Q2_ready,
  output logic [31:0] Q2_value,
  // retirement
  output logic        RF_commit_valid,
  output logic [4:0]  RF_rd,
  output logic [31:0] RF_value,
  output rob_id_t     RF_commit_ROB_id,
  output logic        LSB_store_commit,
  output rob_id_t     LSB_store_ROB_id,
  output logic        ROB_roll_back_flag,
  output logic [31:0] ROB_jump_pc
);

  // Entry status (reset) and payload (no reset needed: only read when busy).
  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_ready;
  id_type_e            r_type       [ROB_SIZE];
  logic                r_rd_valid   [ROB_SIZE];
  logic [4:0]          r_rd         [ROB_SIZE];
  logic [31:0]         r_value      [ROB_SIZE];
  logic                r_pred_taken [ROB_SIZE];
  logic                r_taken      [ROB_SIZE];
  logic [31:0]         r_target_pc  [ROB_SIZE];

  rob_id_t  r_head;
  rob_id_t  r_tail;
  rob_cnt_t r_count;
  logic     r_full;

  logic        r_rf_commit_valid;
  logic [4:0]  r_rf_rd;
  logic [31:0] r_rf_value;
  rob_id_t     r_rf_commit_id;
  logic        r_store_commit;
  rob_id_t     r_store_id;
  logic        r_roll_back;
  logic [31:0] r_jump_pc;

  logic     w_issue;
  logic     w_alu_hit;
  logic     w_lsb_hit;
  logic     w_commit;
  logic     w_mispredict;
  rob_cnt_t w_count_next;

  always_comb begin
    w_issue      = ID_issue_valid && !r_full && !r_roll_back;
    w_alu_hit    = ALU_valid && !r_roll_back && r_busy[ALU_ROB_id];
    w_lsb_hit    = LSB_valid && !r_roll_back && r_busy[LSB_ROB_id];
    w_commit     = r_busy[r_head] && r_ready[r_head];
    w_mispredict = w_commit && (r_type[r_head] == TYPE_BRANCH) &&
                   (r_taken[r_head] != r_pred_taken[r_head]);
    w_count_next = r_count + rob_cnt_t'(w_issue) - rob_cnt_t'(w_commit);
  end

  // Control state and retirement pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy            <= '0;
      r_ready           <= '0;
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_full            <= FALSE;
      r_rf_commit_valid <= FALSE;
      r_rf_rd           <= '0;
      r_rf_value        <= '0;
      r_rf_commit_id    <= '0;
      r_store_commit    <= FALSE;
      r_store_id        <= '0;
      r_roll_back       <= FALSE;
      r_jump_pc         <= '0;
    end else if (rdy) begin
      r_rf_commit_valid <= FALSE;
      r_store_commit    <= FALSE;
      r_roll_back       <= FALSE;

      if (w_issue) begin
        r_busy[r_tail]  <= TRUE;
        r_ready[r_tail] <= FALSE;
        r_tail          <= r_tail + rob_id_t'(1);
      end
      if (w_alu_hit) r_ready[ALU_ROB_id] <= TRUE;
      if (w_lsb_hit) r_ready[LSB_ROB_id] <= TRUE;

      if (w_commit) begin
        r_busy[r_head] <= FALSE;
        r_head         <= r_head + rob_id_t'(1);
        case (r_type[r_head])
          TYPE_STORE: begin
            r_store_commit <= TRUE;
            r_store_id     <= r_head;
          end
          TYPE_BRANCH: begin
            if (w_mispredict) begin
              r_roll_back <= TRUE;
              r_jump_pc   <= r_target_pc[r_head];
            end
          end
          default: begin
            r_rf_commit_valid <= r_rd_valid[r_head];
            r_rf_rd           <= r_rd[r_head];
            r_rf_value        <= r_value[r_head];
            r_rf_commit_id    <= r_head;
          end
        endcase
      end

      r_count <= w_count_next;
      r_full  <= (w_count_next == ROB_COUNT_FULL);

      // Flush overrides everything above, including a same-cycle issue.
      if (w_mispredict) begin
        r_busy  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_full  <= FALSE;
      end
    end
  end

  // Entry payload. An issuing entry is never busy, so issue and broadcast
  // writes can never target the same index on one edge.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (w_issue) begin
        r_type[r_tail]       <= id_type_e'(ID_type);
        r_rd_valid[r_tail]   <= ID_rd_valid;
        r_rd[r_tail]         <= ID_rd;
        r_pred_taken[r_tail] <= ID_pred_taken;
      end
      if (w_lsb_hit) begin
        r_value[LSB_ROB_id] <= LSB_value;
      end
      if (w_alu_hit) begin
        r_value[ALU_ROB_id]     <= ALU_value;
        r_taken[ALU_ROB_id]     <= ALU_taken;
        r_target_pc[ALU_ROB_id] <= ALU_target_pc;
      end
    end
  end

  rob_query_port u_q1 (
    .i_q_id      (Q1_id),
    .i_busy      (r_busy),
    .i_ready     (r_ready),
    .i_value     (r_value),
    .i_alu_valid (ALU_valid),
    .i_alu_id    (ALU_ROB_id),
    .i_alu_value (ALU_value),
    .i_lsb_valid (LSB_valid),
    .i_lsb_id    (LSB_ROB_id),
    .i_lsb_value (LSB_value),
    .o_ready     (Q1_ready),
    .o_value     (Q1_value)
  );

  rob_query_port u_q2 (
    .i_q_id      (Q2_id),
    .i_busy      (r_busy),
    .i_ready     (r_ready),
    .i_value     (r_value),
    .i_alu_valid (ALU_valid),
    .i_alu_id    (ALU_ROB_id),
    .i_alu_value (ALU_value),
    .i_lsb_valid (LSB_valid),
    .i_lsb_id    (LSB_ROB_id),
    .i_lsb_value (LSB_value),
    .o_ready     (Q2_ready),
    .o_value     (Q2_value)
  );

  assign ROB_free_id        = r_tail;
  assign ROB_full           = r_full;
  assign RF_commit_valid    = r_rf_commit_valid;
  assign RF_rd              = r_rf_rd;
  assign RF_value           = r_rf_value;
  assign RF_commit_ROB_id   = r_rf_commit_id;
  assign LSB_store_commit   = r_store_commit;
  assign LSB_store_ROB_id   = r_store_id;
  assign ROB_roll_back_flag = r_roll_back;
  assign ROB_jump_pc        = r_jump_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
// Directed bench for reorder_buffer: in-order write-back, full/wrap, out of
// order completion, mispredict flush, store release, branch retire, freeze,
// and operand query timing with or without ROB_CDB_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ID_issue_valid;
  logic [1:0]  ID_type;
  logic        ID_rd_valid;
  logic [4:0]  ID_rd;
  logic        ID_pred_taken;
  logic [3:0]  ROB_free_id;
  logic        ROB_full;
  logic        ALU_valid;
  logic [3:0]  ALU_ROB_id;
  logic [31:0] ALU_value;
  logic        ALU_taken;
  logic [31:0] ALU_target_pc;
  logic        LSB_valid;
  logic [3:0]  LSB_ROB_id;
  logic [31:0] LSB_value;
  logic [3:0]  Q1_id;
  logic [3:0]  Q2_id;
  logic        Q1_ready;
  logic [31:0] Q1_value;
  logic        Q2_ready;
  logic [31:0] Q2_value;
  logic        RF_commit_valid;
  logic [4:0]  RF_rd;
  logic [31:0] RF_value;
  logic [3:0]  RF_commit_ROB_id;
  logic        LSB_store_commit;
  logic [3:0]  LSB_store_ROB_id;
  logic        ROB_roll_back_flag;
  logic [31:0] ROB_jump_pc;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_val;

  reorder_buffer dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .ID_issue_valid     (ID_issue_valid),
    .ID_type            (ID_type),
    .ID_rd_valid        (ID_rd_valid),
    .ID_rd              (ID_rd),
    .ID_pred_taken      (ID_pred_taken),
    .ROB_free_id        (ROB_free_id),
    .ROB_full           (ROB_full),
    .ALU_valid          (ALU_valid),
    .ALU_ROB_id         (ALU_ROB_id),
    .ALU_value          (ALU_value),
    .ALU_taken          (ALU_taken),
    .ALU_target_pc      (ALU_target_pc),
    .LSB_valid          (LSB_valid),
    .LSB_ROB_id         (LSB_ROB_id),
    .LSB_value          (LSB_value),
    .Q1_id              (Q1_id),
    .Q2_id              (Q2_id),
    .Q1_ready           (Q1_ready),
    .Q1_value           (Q1_value),
    .Q2_ready           (Q2_ready),
    .Q2_value           (Q2_value),
    .RF_commit_valid    (RF_commit_valid),
    .RF_rd              (RF_rd),
    .RF_value           (RF_value),
    .RF_commit_ROB_id   (RF_commit_ROB_id),
    .LSB_store_commit   (LSB_store_commit),
    .LSB_store_ROB_id   (LSB_store_ROB_id),
    .ROB_roll_back_flag (ROB_roll_back_flag),
    .ROB_jump_pc        (ROB_jump_pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Asynchronous reset: state must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_val("async_rst_free_id", 32'(ROB_free_id), 32'd0);
    tick();
    rst = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] typ, input logic rdv,
                       input logic [4:0] rd, input logic pred);
    ID_issue_valid = 1'b1;
    ID_type        = typ;
    ID_rd_valid    = rdv;
    ID_rd          = rd;
    ID_pred_taken  = pred;
    tick();
    ID_issue_valid = 1'b0;
  endtask

  task automatic alu_bc(input logic [3:0] id, input logic [31:0] val,
                        input logic tk, input logic [31:0] tgt);
    ALU_valid     = 1'b1;
    ALU_ROB_id    = id;
    ALU_value     = val;
    ALU_taken     = tk;
    ALU_target_pc = tgt;
    tick();
    ALU_valid = 1'b0;
  endtask

  task automatic lsb_bc(input logic [3:0] id, input logic [31:0] val);
    LSB_valid  = 1'b1;
    LSB_ROB_id = id;
    LSB_value  = val;
    tick();
    LSB_valid = 1'b0;
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    rst = 1'b0; rdy = 1'b1;
    ID_issue_valid = 1'b0; ID_type = 2'd0; ID_rd_valid = 1'b0;
    ID_rd = 5'd0; ID_pred_taken = 1'b0;
    ALU_valid = 1'b0; ALU_ROB_id = 4'd0; ALU_value = 32'd0;
    ALU_taken = 1'b0; ALU_target_pc = 32'd0;
    LSB_valid = 1'b0; LSB_ROB_id = 4'd0; LSB_value = 32'd0;
    Q1_id = 4'd0; Q2_id = 4'd0;
    tick();
    tick();

    // Reset state
    check_val("rst_free_id", 32'(ROB_free_id), 32'd0);
    check_val("rst_full", 32'(ROB_full), 32'd0);
    check_val("rst_rf_valid", 32'(RF_commit_valid), 32'd0);
    check_val("rst_store", 32'(LSB_store_commit), 32'd0);
    check_val("rst_rollback", 32'(ROB_roll_back_flag), 32'd0);
    check_val("rst_jump_pc", ROB_jump_pc, 32'd0);
    check_val("rst_q1_ready", 32'(Q1_ready), 32'd0);
    rst = 1'b1;

    // 1) Basic ALU write-back, two cycles after issue
    issue(2'd0, 1'b1, 5'd5, 1'b0);
    check_val("t1_free_id", 32'(ROB_free_id), 32'd1);
    alu_bc(4'd0, 32'h1234, 1'b0, 32'd0);
    check_val("t1_no_early_commit", 32'(RF_commit_valid), 32'd0);
    tick();
    check_val("t1_rf_valid", 32'(RF_commit_valid), 32'd1);
    check_val("t1_rf_rd", 32'(RF_rd), 32'd5);
    check_val("t1_rf_value", RF_value, 32'h1234);
    check_val("t1_rf_id", 32'(RF_commit_ROB_id), 32'd0);
    tick();
    check_val("t1_pulse_low", 32'(RF_commit_valid), 32'd0);

    // 2) Fill, drop when full, free one entry, wrap to id 0
    do_reset();
    ID_issue_valid = 1'b1; ID_type = 2'd0; ID_rd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ID_rd = 5'(i + 1);
      tick();
    end
    ID_issue_valid = 1'b0;
    check_val("t2_full", 32'(ROB_full), 32'd1);
    check_val("t2_tail_wrapped", 32'(ROB_free_id), 32'd0);
    issue(2'd0, 1'b1, 5'd30, 1'b0);
    check_val("t2_drop_full", 32'(ROB_full), 32'd1);
    check_val("t2_drop_tail", 32'(ROB_free_id), 32'd0);
    alu_bc(4'd0, 32'h55, 1'b0, 32'd0);
    tick();
    check_val("t2_not_full", 32'(ROB_full), 32'd0);
    check_val("t2_commit_rd", 32'(RF_rd), 32'd1);
    check_val("t2_commit_val", RF_value, 32'h55);
    issue(2'd0, 1'b1, 5'd20, 1'b0);
    check_val("t2_wrap_free_id", 32'(ROB_free_id), 32'd1);
    check_val("t2_full_again", 32'(ROB_full), 32'd1);
    Q1_id = 4'd0;
    #1;
    check_val("t2_reissued_not_ready", 32'(Q1_ready), 32'd0);

    // 3) Out-of-order completion, in-order retirement
    do_reset();
    issue(2'd0, 1'b1, 5'd1, 1'b0);
    issue(2'd0, 1'b1, 5'd2, 1'b0);
    issue(2'd0, 1'b1, 5'd3, 1'b0);
    alu_bc(4'd2, 32'hC2, 1'b0, 32'd0);
    check_val("t3_wait_head_a", 32'(RF_commit_valid), 32'd0);
    lsb_bc(4'd1, 32'hC1);
    check_val("t3_wait_head_b", 32'(RF_commit_valid), 32'd0);
    alu_bc(4'd0, 32'hC0, 1'b0, 32'd0);
    exp_q.push_back(32'hC0);
    exp_q.push_back(32'hC1);
    exp_q.push_back(32'hC2);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_val = exp_q.pop_front();
      check_val("t3_order_valid", 32'(RF_commit_valid), 32'd1);
      check_val("t3_order_id", 32'(RF_commit_ROB_id), 32'(i));
      check_val("t3_order_value", RF_value, exp_val);
    end
    tick();
    check_val("t3_drained", 32'(RF_commit_valid), 32'd0);

    // 4) Branch mispredict flush
    do_reset();
    issue(2'd1, 1'b0, 5'd0, 1'b0);
    issue(2'd0, 1'b1, 5'd7, 1'b0);
    issue(2'd0, 1'b1, 5'd8, 1'b0);
    alu_bc(4'd0, 32'd0, 1'b1, 32'h80);
    tick();
    check_val("t4_rollback", 32'(ROB_roll_back_flag), 32'd1);
    check_val("t4_jump_pc", ROB_jump_pc, 32'h80);
    check_val("t4_free_id", 32'(ROB_free_id), 32'd0);
    check_val("t4_no_rf", 32'(RF_commit_valid), 32'd0);
    issue(2'd0, 1'b1, 5'd9, 1'b0);
    check_val("t4_issue_ignored", 32'(ROB_free_id), 32'd0);
    check_val("t4_rollback_pulse", 32'(ROB_roll_back_flag), 32'd0);
    issue(2'd0, 1'b1, 5'd9, 1'b0);
    check_val("t4_issue_resumes", 32'(ROB_free_id), 32'd1);
    Q1_id = 4'd1;
    #1;
    check_val("t4_old_entry_gone", 32'(Q1_ready), 32'd0);

    // 5) Store release and correctly predicted branch
    do_reset();
    issue(2'd2, 1'b0, 5'd0, 1'b0);
    issue(2'd1, 1'b0, 5'd0, 1'b1);
    lsb_bc(4'd0, 32'hDEAD);
    tick();
    check_val("t5_store_commit", 32'(LSB_store_commit), 32'd1);
    check_val("t5_store_id", 32'(LSB_store_ROB_id), 32'd0);
    check_val("t5_store_no_rf", 32'(RF_commit_valid), 32'd0);
    alu_bc(4'd1, 32'd0, 1'b1, 32'h40);
    check_val("t5_store_pulse", 32'(LSB_store_commit), 32'd0);
    Q1_id = 4'd1;
    #1;
    check_val("t5_branch_ready", 32'(Q1_ready), 32'd1);
    tick();
    check_val("t5_branch_no_rb", 32'(ROB_roll_back_flag), 32'd0);
    check_val("t5_branch_no_rf", 32'(RF_commit_valid), 32'd0);
    check_val("t5_branch_retired", 32'(Q1_ready), 32'd0);
    check_val("t5_free_id", 32'(ROB_free_id), 32'd2);

    // 6) rdy = 0 freezes issue
    rdy = 1'b0;
    issue(2'd0, 1'b1, 5'd4, 1'b0);
    check_val("t6_freeze", 32'(ROB_free_id), 32'd2);
    rdy = 1'b1;

    // 7) Operand query against a same-cycle broadcast
    do_reset();
    for (int i = 0; i < 4; i++) issue(2'd0, 1'b1, 5'(i + 10), 1'b0);
    Q1_id = 4'd3;
    Q2_id = 4'd2;
    ALU_valid = 1'b1; ALU_ROB_id = 4'd3; ALU_value = 32'h33;
    ALU_taken = 1'b0; ALU_target_pc = 32'd0;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    check_val("t7_q1_same_cycle", 32'(Q1_ready), 32'd1);
    check_val("t7_q1_bypass_val", Q1_value, 32'h33);
`else
    check_val("t7_q1_same_cycle", 32'(Q1_ready), 32'd0);
`endif
    check_val("t7_q2_not_ready", 32'(Q2_ready), 32'd0);
    tick();
    ALU_valid = 1'b0;
    #1;
    check_val("t7_q1_next_cycle", 32'(Q1_ready), 32'd1);
    check_val("t7_q1_value", Q1_value, 32'h33);
    check_val("t7_q2_still", 32'(Q2_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order retirement queue between the decoder/issue stage and the register file. It allocates one entry per issued instruction and hands that entry's ROB id to the register file as the destination rename tag. It collects results from the ALU and load/store broadcast buses and retires entries strictly in program order. On retirement it writes back to the register file, releases stores to the LSBuffer, and raises the pipeline-wide roll-back on a branch mispredict.

## Interface
- ROB_SIZE, 16, entry count (power of two); id width ROBW = log2(ROB_SIZE) = 4
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  0 freezes all state; registered outputs hold
- ID_issue_valid  in  1  allocate entry this cycle
- ID_type  in  2  0 = ALU/load, 1 = branch, 2 = store
- ID_rd_valid / ID_rd  in  1/5  entry writes a register / destination index
- ID_pred_taken  in  1  predictor decision (branch only)
- ROB_free_id  out  ROBW  tail id, combinational; the id the next issued entry receives
- ROB_full  out  1  registered; count == ROB_SIZE
- ALU_valid / ALU_ROB_id / ALU_value  in  1/ROBW/32  ALU broadcast
- ALU_taken / ALU_target_pc  in  1/32  branch outcome, actual next PC
- LSB_valid / LSB_ROB_id / LSB_value  in  1/ROBW/32  load result or store-address-ready broadcast
- Q1_id / Q2_id  in  ROBW  operand query ids
- Q1_ready / Q1_value, Q2_ready / Q2_value  out  1/32  combinational query answers
- RF_commit_valid / RF_rd / RF_value / RF_commit_ROB_id  out  1/5/32/ROBW  register write-back, registered pulse
- LSB_store_commit / LSB_store_ROB_id  out  1/ROBW  store release, registered pulse
- ROB_roll_back_flag / ROB_jump_pc  out  1/32  mispredict flush, registered pulse

## Operation
- Entry fields: busy, ready, type, rd_valid, rd, value, pred_taken, taken, target_pc.
- State: head, tail (ROBW bits, wrap modulo ROB_SIZE), count (ROBW+1 bits).
- Issue:
  - Accepted only when ID_issue_valid, ROB_full == 0 and ROB_roll_back_flag == 0.
  - Writes the entry at tail with busy = 1 and ready = 0, then tail += 1.
  - Issue while full is dropped; the decoder must stall on ROB_full.
- Writeback:
  - A valid broadcast whose id names a busy entry sets ready = 1 and records value. An ALU broadcast also records taken and target_pc.
  - A broadcast to a non-busy entry is ignored.
  - ALU and LSB broadcasts to different ids in the same cycle are both applied.
- Commit: at most one entry per cycle. The head entry commits when busy and ready.
  - ALU/load entry: RF_commit_valid = rd_valid, RF_rd = rd, RF_value = value, RF_commit_ROB_id = head.
  - Store entry: LSB_store_commit = 1, LSB_store_ROB_id = head.
  - Branch entry, taken == pred_taken: the entry retires with no further action.
  - Branch entry, taken != pred_taken (mispredict): ROB_roll_back_flag = 1 and ROB_jump_pc = target_pc. On the same edge, head = tail = count = 0 and every busy bit is cleared.
- Count: the count update accounts for issue and commit in the same cycle (net 0).
- Query: Qn_ready = busy[Qn_id] & ready[Qn_id]; Qn_value = value[Qn_id]. The value is undefined when not ready.

## Timing
- Reset: every output is 0, ROB_free_id = 0 and ROB_full = 0. Head, tail, count and all busy bits are cleared.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency chain:
  - Issue at edge E makes the entry visible from E.
  - A broadcast at edge E+1 sets ready.
  - The commit pulse is high during the cycle after edge E+2.
  - Minimum issue-to-commit latency is 2 cycles.
- Every commit and roll-back output is a single-cycle pulse and is deasserted in the next cycle unless another commit occurs.
- During the cycle in which ROB_roll_back_flag is high, issue and broadcasts are ignored. Issue resumes the following cycle at id 0.
- Full to not-full: ROB_full falls on the edge after the commit that frees the entry. Issue is possible one cycle after that.
- Wrap-around: tail moves from 15 to 0 without a gap. Ids are reused only after the previous owner has committed.

## Configuration
- ROB_CDB_BYPASS_EN
  - Defined: an operand query whose id matches a same-cycle ALU_valid or LSB_valid broadcast returns ready = 1 and the broadcast value, combinationally.
  - Undefined: the query reflects stored state only, so the value is available one cycle after the broadcast.

## Structure
- Shared package/defines file:
  - ROB_SIZE and ROBW
  - the ROBIDBus width
  - the ID_type encodings
  - the True/False constants
- One sub-module, rob_query_port, implements one query lookup, including the optional bypass. It is instantiated twice (Q1, Q2).

## Test plan
- Reset, issue ALU entry rd = 5; ALU broadcast id 0 value 0x1234 next cycle -> RF_commit_valid pulse with RF_rd = 5, RF_value = 0x1234, RF_commit_ROB_id = 0, two cycles after issue.
- Issue 16 entries -> ROB_full = 1, a 17th issue is dropped. Commit one entry -> ROB_full = 0, the next issue gets id 0 (wrap).
- Results broadcast out of order (id 2, then 1, then 0) -> commits in order 0, 1, 2, one per cycle.
- Branch at id 0 with pred_taken = 0, ALU_taken = 1, target 0x80 -> roll-back pulse with ROB_jump_pc = 0x80. Following entries are discarded and ROB_free_id = 0.
- Store entry broadcast ready by LSB -> LSB_store_commit = 1 with its id, and RF_commit_valid stays 0.
- Q1_id = 3 queried while an ALU broadcast to id 3 occurs -> Q1_ready = 1 in the same cycle with the macro defined, in the next cycle without it.
